// File: rtl/mac_seq.sv
// mac_seq: multi-cycle MAC sequencer beside the IEU datapath.
// Owns the accumulator and an iterative shift-add multiplier that retires
// BPC multiplier bits per cycle. MAC holds Execute via MacStallE. CLR, SET
// and RD commit in a single cycle. Results go to Memory with a done pulse.
module mac_seq #(
  parameter int XLEN = 64,
  parameter int BPC  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MacValidE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            MacStallE,
  output logic            MacBusyE,
  output logic            MacDoneM,
  output logic [XLEN-1:0] MacResultM,
  output logic [XLEN-1:0] AccQ
);

  localparam int N  = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_MAC = 3'b000;
  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_SET = 3'b011;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            done_q, done_d;

  // Instruction may act this cycle: present, not flushed, not held upstream.
  logic accept;
  assign accept = MacValidE & ~FlushE & ~StallE;

  // One multiplier step: low BPC bits of a times b, placed at the digit
  // position of this iteration, added to the partial product modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pp_step(input logic [XLEN-1:0] p,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b,
                                              input logic [CW-1:0]   cnt);
    logic [XLEN-1:0] prod;
    prod = XLEN'(a[BPC-1:0]) * b;
    return p + (prod << (32'(cnt) * BPC));
  endfunction

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a flush in RUN or DONE always wins over a commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && Funct3E == OP_MAC) state_d = RUN;
      RUN: begin
        if (FlushE)                        state_d = IDLE;
        else if (cnt_q == CW'(N - 1))      state_d = DONE;
      end
      DONE: if (FlushE || !StallE)         state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // FSM outputs; the stall request never looks at StallE to avoid a loop.
  always_comb begin
    MacStallE = 1'b0;
    MacBusyE  = 1'b0;
    case (state_q)
      IDLE: MacStallE = MacValidE && (Funct3E == OP_MAC);
      RUN: begin
        MacStallE = 1'b1;
        MacBusyE  = 1'b1;
      end
      DONE:    MacBusyE = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: operand capture, iteration, and commits.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    res_d  = res_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (Funct3E)
            OP_MAC: begin
              a_d   = SrcAE;
              b_d   = SrcBE;
              p_d   = '0;
              cnt_d = '0;
            end
            OP_CLR: begin
              acc_d  = '0;
              res_d  = '0;
              done_d = 1'b1;
            end
            OP_SET: begin
              acc_d  = SrcAE;
              res_d  = SrcAE;
              done_d = 1'b1;
            end
            default: begin
              res_d  = acc_q;
              done_d = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        if (!FlushE) begin
          p_d   = pp_step(p_q, a_q, b_q, cnt_q);
          a_d   = a_q >> BPC;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!FlushE && !StallE) begin
          acc_d  = acc_q + p_q;
          res_d  = acc_q + p_q;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, mid-operation included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign MacDoneM   = done_q;
  assign MacResultM = res_q;
  assign AccQ       = acc_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: scenario tasks against an accumulator-level reference model.
module tb_mac_seq;
  localparam int XLEN = 64;
  localparam int BPC  = 8;
  localparam int N    = XLEN / BPC;

  logic            clk = 1'b0;
  logic            reset;
  logic            MacValidE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] SrcAE, SrcBE;
  logic            StallE, FlushE;
  logic            MacStallE, MacBusyE, MacDoneM;
  logic [XLEN-1:0] MacResultM, AccQ;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural accumulator and last committed result.
  logic [XLEN-1:0] acc_m;
  logic [XLEN-1:0] res_m;

  always #5 clk = ~clk;

  mac_seq #(.XLEN(XLEN), .BPC(BPC)) dut (
    .clk(clk), .reset(reset), .MacValidE(MacValidE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallE(StallE), .FlushE(FlushE),
    .MacStallE(MacStallE), .MacBusyE(MacBusyE), .MacDoneM(MacDoneM),
    .MacResultM(MacResultM), .AccQ(AccQ)
  );

  task automatic drive_idle();
    MacValidE = 1'b0; Funct3E = 3'b000; SrcAE = '0; SrcBE = '0;
    StallE = 1'b0; FlushE = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic check_all_zero(input string tag);
    checks++;
    if ({MacDoneM, MacBusyE, MacStallE} !== 3'b000 || MacResultM !== '0 || AccQ !== '0) begin
      errors++;
      $display("FAIL %s: done=%b busy=%b stall=%b res=%h acc=%h, required all zero",
               tag, MacDoneM, MacBusyE, MacStallE, MacResultM, AccQ);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;
    acc_m = '0;
    res_m = '0;
  endtask

  // Single-cycle op (CLR/SET/RD/other); called at posedge+1.
  task automatic do_simple(input logic [2:0] f3, input logic [XLEN-1:0] a);
    MacValidE = 1'b1; Funct3E = f3; SrcAE = a; SrcBE = rnd64();
    if (f3 == 3'b001)      acc_m = '0;
    else if (f3 == 3'b011) acc_m = a;
    res_m = acc_m;
    @(negedge clk);
    checks++;
    if (MacStallE !== 1'b0) begin
      errors++; $display("FAIL simple_nostall f3=%b: got %b required 0", f3, MacStallE);
    end
    @(posedge clk); #1;
    MacValidE = 1'b0;
    checks++;
    if (MacDoneM !== 1'b1 || MacResultM !== res_m || AccQ !== acc_m) begin
      errors++;
      $display("FAIL simple_commit f3=%b: done=%b res=%h acc=%h required done=1 res=%h acc=%h",
               f3, MacDoneM, MacResultM, AccQ, res_m, acc_m);
    end
  endtask

  // Full MAC; optionally holds StallE for 'hold' cycles while in DONE.
  task automatic do_mac(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int hold);
    logic [XLEN-1:0] expv;
    int stall_n, busy_n, cyc, held, left;
    logic ms, leave, was_held;
    expv = acc_m + a * b;
    stall_n = 0; busy_n = 0; cyc = 0; held = 0; left = hold; leave = 1'b0;
    MacValidE = 1'b1; Funct3E = 3'b000; SrcAE = a; SrcBE = b; StallE = 1'b0;
    while (!leave && cyc < 64) begin
      @(negedge clk);
      ms = MacStallE;
      if (ms) stall_n++;
      if (MacBusyE) busy_n++;
      was_held = 1'b0;
      if (!ms && MacBusyE && left > 0) begin
        StallE = 1'b1; left--; held++; was_held = 1'b1;
      end else begin
        StallE = 1'b0;
      end
      leave = !ms && !StallE;
      @(posedge clk); #1;
      cyc++;
      if (was_held) begin
        checks++;
        if (MacDoneM !== 1'b0 || AccQ !== acc_m || MacBusyE !== 1'b1) begin
          errors++;
          $display("FAIL done_hold: done=%b acc=%h busy=%b required done=0 acc=%h busy=1",
                   MacDoneM, AccQ, MacBusyE, acc_m);
        end
      end
    end
    MacValidE = 1'b0; StallE = 1'b0;
    checks++;
    if (!leave) begin
      errors++; $display("FAIL mac_timeout: still in Execute after %0d cycles, required %0d", cyc, N + 2 + hold);
    end
    acc_m = expv;
    res_m = expv;
    checks++;
    if (MacDoneM !== 1'b1 || MacResultM !== expv || AccQ !== expv) begin
      errors++;
      $display("FAIL mac_commit a=%h b=%h: done=%b res=%h acc=%h required done=1 res=%h",
               a, b, MacDoneM, MacResultM, AccQ, expv);
    end
    checks++;
    if (stall_n != N + 1 || cyc - held != N + 2 || busy_n != N + 1 + held) begin
      errors++;
      $display("FAIL mac_timing: stall=%0d occ=%0d busy=%0d required stall=%0d occ=%0d busy=%0d",
               stall_n, cyc - held, busy_n, N + 1, N + 2, N + 1 + held);
    end
  endtask

  task automatic test_set_mac();
    do_simple(3'b011, 64'd5);
    do_mac(64'd3, 64'd4, 0);
    checks++;
    if (AccQ !== 64'd17) begin
      errors++; $display("FAIL set_mac_17: got %0d required 17", AccQ);
    end
  endtask

  task automatic test_back_to_back();
    do_simple(3'b001, rnd64());
    do_mac(64'd2, 64'd3, 0);
    do_mac(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    checks++;
    if (MacResultM !== 64'd4) begin
      errors++; $display("FAIL b2b_wrap: got %h required 4", MacResultM);
    end
    @(posedge clk); #1;
    checks++;
    if (MacDoneM !== 1'b0) begin
      errors++; $display("FAIL done_single_pulse: got %b required 0", MacDoneM);
    end
  endtask

  task automatic test_flush();
    int pulses;
    MacValidE = 1'b1; Funct3E = 3'b000; SrcAE = rnd64(); SrcBE = rnd64();
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (MacBusyE !== 1'b1 || MacStallE !== 1'b1) begin
      errors++; $display("FAIL flush_in_run: busy=%b stall=%b required 1 1", MacBusyE, MacStallE);
    end
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0; MacValidE = 1'b0;
    checks++;
    if (MacBusyE !== 1'b0 || MacDoneM !== 1'b0 || AccQ !== acc_m || MacResultM !== res_m) begin
      errors++;
      $display("FAIL flush_abort: busy=%b done=%b acc=%h res=%h required 0 0 %h %h",
               MacBusyE, MacDoneM, AccQ, MacResultM, acc_m, res_m);
    end
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (MacDoneM) pulses++; end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL flush_no_done: got %0d pulses required 0", pulses);
    end
    do_simple(3'b010, '0);
  endtask

  task automatic test_stall_done();
    int pulses;
    do_mac(rnd64(), rnd64(), 3);
    pulses = 0;
    repeat (5) begin @(posedge clk); #1; if (MacDoneM) pulses++; end
    checks++;
    if (pulses != 0 || AccQ !== acc_m) begin
      errors++; $display("FAIL stall_single_commit: extra pulses=%0d acc=%h required 0 %h", pulses, AccQ, acc_m);
    end
  endtask

  task automatic test_reset_mid();
    do_simple(3'b011, rnd64());
    MacValidE = 1'b1; Funct3E = 3'b000; SrcAE = rnd64(); SrcBE = rnd64();
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0; MacValidE = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_mid_run");
    reset = 1'b1;
    acc_m = '0; res_m = '0;
    do_simple(3'b010, rnd64());
  endtask

  task automatic test_simple_ops();
    do_simple(3'b011, rnd64());
    do_simple(3'b010, '0);
    do_simple(3'b111, '0);
    do_simple(3'b001, rnd64());
    do_simple(3'b010, '0);
    do_simple(3'b011, rnd64());
    do_simple(3'b100, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) do_mac(rnd64(), rnd64(), (r == 0) ? int'($urandom_range(1, 3)) : 0);
      else       do_simple(3'(r - 2), rnd64());
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_set_mac();
    test_back_to_back();
    test_flush();
    test_stall_done();
    test_reset_mid();
    test_simple_ops();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq.md
# mac_seq

Multi-cycle sequencer for the custom MAC instruction in the integer execution unit. It owns an XLEN-bit accumulator and an iterative shift-add multiplier. It holds a MAC instruction in Execute by requesting a stall from the hazard unit, then commits `acc + SrcA*SrcB` when the instruction leaves Execute. It sits beside the IEU datapath: it takes forwarded sources from the Execute stage and delivers its result to the Memory stage, alongside the `mac_valid` pipeline flags.

## Interface
Parameters:
- `XLEN`, 64, operand/accumulator width (from `P.XLEN`).
- `BPC`, 8, multiplier bits retired per cycle; must divide `XLEN`. `N = XLEN/BPC`.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset.
- `MacValidE`  in  1  custom MAC-class instruction in Execute.
- `Funct3E`  in  3  op: 000 MAC, 001 CLR, 010 RD, 011 SET, others treated as RD.
- `SrcAE`, `SrcBE`  in  XLEN  forwarded sources (`ForwardedSrcAE`/`ForwardedSrcBE`).
- `StallE`  in  1  Execute stall from the hazard unit.
- `FlushE`  in  1  Execute flush.
- `MacStallE`  out  1  request to hold the instruction in Execute.
- `MacBusyE`  out  1  FSM not IDLE.
- `MacDoneM`  out  1  one-cycle pulse: `MacResultM` is valid for the instruction now in Memory.
- `MacResultM`  out  XLEN  result to the Memory stage.
- `AccQ`  out  XLEN  current accumulator (debug/trace).

## Operation
States: IDLE, RUN, DONE. The block keeps operand registers `a`, `b`, a partial product `p` (XLEN), a counter `cnt` of width log2(N), and the accumulator `acc`.

- **IDLE**
  - If `MacValidE & ~FlushE & Funct3E==000`:
    - `MacStallE=1` (combinational).
    - Latch `a=SrcAE`, `b=SrcBE`; set `p=0`, `cnt=0`.
    - Go to RUN.
  - If `MacValidE & ~FlushE & ~StallE` with any other op, commit in one cycle with no stall:
    - CLR: `acc<=0`, `MacResultM<=0`.
    - SET: `acc<=SrcAE`, `MacResultM<=SrcAE`.
    - RD/other: `MacResultM<=acc`.
    - Assert `MacDoneM` on the next cycle.
  - If `StallE` is high, take no action; the op re-evaluates next cycle.
- **RUN**
  - `MacStallE=1`.
  - Each cycle: `p <= p + ((a[BPC-1:0] * b) << (cnt*BPC))`, truncated to XLEN; `a >>= BPC`; `cnt++`.
  - After the cycle with `cnt==N-1`, go to DONE.
- **DONE**
  - `MacStallE=0`.
  - If `~StallE`: `acc <= acc + p`, `MacResultM <= acc + p`, pulse `MacDoneM` next cycle, go to IDLE.
  - If `StallE`: hold DONE with state unchanged.
- **FlushE** in RUN or DONE aborts to IDLE next cycle. `acc` is unchanged and there is no `MacDoneM`.
- **Arithmetic:** low XLEN bits of the product only, so sign is irrelevant. Accumulator addition wraps modulo 2^XLEN.
- **Back-to-back MACs:** the second is seen in IDLE the cycle after the first commits, and its operands reflect the forwarded updated `rd` as usual.
- **Reset (`reset==0`)**, from any state, mid-operation included:
  - State=IDLE.
  - `acc`, `p`, `a`, `b`, `cnt`, `MacResultM` = 0.
  - `MacDoneM=0`, `MacStallE=0`, `MacBusyE=0`.

## Timing
- A MAC instruction occupies Execute for N+2 cycles when there is no external stall: start cycle, N RUN cycles, DONE cycle. XLEN=64, BPC=8 gives 10 cycles.
- `MacStallE` is high for exactly N+1 cycles per MAC and depends combinationally on state, `MacValidE` and `Funct3E` only. It never depends on `StallE`, which avoids a loop.
- CLR/SET/RD take 0 extra cycles.
- `MacResultM` and `MacDoneM` are registered and appear the cycle the instruction enters Memory. `MacResultM` holds its value until the next commit.
- `MacBusyE` is high in RUN and DONE.
- `AccQ` is updated on the commit edge.
- When a flush and a commit fall in the same cycle, the flush wins: no commit.

## Test plan
- Reset, then SET `SrcAE=5`; then MAC `a=3`, `b=4` → `MacStallE` high for 9 cycles, `MacDoneM` pulse, `MacResultM=17`, `AccQ=17`.
- Back-to-back MACs (`2*3`, then `0xFFFFFFFFFFFFFFFF*2`) from `acc=0` → results 6, then 4 (wrap); each has a 10-cycle Execute occupancy.
- `FlushE` asserted on RUN cycle 4 → return to IDLE, no `MacDoneM`, `AccQ` unchanged; a following RD returns the old `acc`.
- `StallE` held 3 cycles while in DONE → state held, commit happens once when `StallE` drops, exactly one `MacDoneM`.
- `reset=0` mid-RUN → all outputs 0 next cycle; a subsequent RD returns 0.
- CLR and RD with `StallE=0` → no stall, `MacDoneM` next cycle, results 0 and current `acc` respectively; `Funct3E=111` behaves as RD.
